// File: rtl/player_move_ctrl.sv
// ---------------------------------------------------------------------------
// player_move_ctrl
//
// Two-player token movement controller for the dice-race board. A dice
// result starts a move; the active player's token then advances one tile per
// step tick so the display shows it hopping tile by tile. When the move is
// finished the controller either declares a winner (token on LAST_TILE) or
// hands the turn to the other player.
//
// Optional build feature (macro BOUNCE_BACK_EN):
//   Undefined: a token that reaches LAST_TILE stops there and any remaining
//              steps are discarded.
//   Defined:   a token that reaches LAST_TILE with steps left walks back
//              for the remaining steps; a win needs an exact landing.
//
// Parameters:
//   STEP_CYCLES  clock cycles between one-tile steps (>= 2)
//   LAST_TILE    goal tile index (<= 15)
//
// Ports:
//   clk          system clock
//   reset        synchronous active-high reset
//   new_game     synchronous restart pulse, same effect as reset
//   dice_valid   one-cycle strobe qualifying dice_value
//   dice_value   dice result, legal range 1..6
//   p0_tile      player 0 tile index
//   p1_tile      player 1 tile index
//   cur_player   player whose turn it is / who is moving
//   busy         high while a move is in progress
//   move_done    one-cycle pulse when a move completes
//   game_over    high once a player has won
//   winner       winning player, valid when game_over is high
// ---------------------------------------------------------------------------
module player_move_ctrl #(
    parameter int STEP_CYCLES = 12_500_000,
    parameter int LAST_TILE   = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       new_game,
    input  logic       dice_valid,
    input  logic [2:0] dice_value,
    output logic [3:0] p0_tile,
    output logic [3:0] p1_tile,
    output logic       cur_player,
    output logic       busy,
    output logic       move_done,
    output logic       game_over,
    output logic       winner
);

    localparam int            TW     = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [TW-1:0] RELOAD = TW'(STEP_CYCLES - 1);
    localparam logic [3:0]    LAST   = 4'(LAST_TILE);

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        DONE,
        OVER
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] timer;
    logic [2:0]    steps_left;
    logic [2:0]    steps_after;
    logic [3:0]    active_tile;
    logic [3:0]    stepped_tile;
    logic          accept;
    logic          step_tick;
    logic          end_move;
`ifdef BOUNCE_BACK_EN
    logic          dir;
`endif

    // Datapath decode: which token is moving, where one step would put it,
    // and whether that step ends the move.
    always_comb begin
        active_tile = cur_player ? p1_tile : p0_tile;
        accept      = (state == IDLE) && dice_valid &&
                      (dice_value != 3'd0) && (dice_value != 3'd7);
        step_tick   = (state == MOVE) && (timer == '0);
        steps_after = steps_left - 3'd1;
`ifdef BOUNCE_BACK_EN
        if (dir) begin
            // The guard keeps a tiny board from wrapping below tile 0.
            stepped_tile = (active_tile == 4'd0) ? 4'd0 : active_tile - 4'd1;
        end else begin
            stepped_tile = active_tile + 4'd1;
        end
        end_move = (steps_after == 3'd0);
`else
        stepped_tile = active_tile + 4'd1;
        // Reaching the goal early discards the remaining steps.
        end_move     = (steps_after == 3'd0) || (stepped_tile == LAST);
`endif
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = MOVE;
            MOVE: if (step_tick && end_move) state_next = DONE;
            // The mover is still cur_player here, so active_tile is its tile.
            DONE: state_next = (active_tile == LAST) ? OVER : IDLE;
            OVER: state_next = OVER;
            default: state_next = IDLE;
        endcase
    end

    // State register; new_game behaves exactly like reset.
    always_ff @(posedge clk) begin
        if (reset || new_game) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered datapath: step timer, step counter, tiles and turn flags.
    always_ff @(posedge clk) begin
        if (reset || new_game) begin
            timer      <= '0;
            steps_left <= 3'd0;
            p0_tile    <= 4'd0;
            p1_tile    <= 4'd0;
            cur_player <= 1'b0;
            busy       <= 1'b0;
            move_done  <= 1'b0;
            game_over  <= 1'b0;
            winner     <= 1'b0;
`ifdef BOUNCE_BACK_EN
            dir        <= 1'b0;
`endif
        end else begin
            move_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        steps_left <= dice_value;
                        timer      <= RELOAD;
                        busy       <= 1'b1;
`ifdef BOUNCE_BACK_EN
                        dir        <= 1'b0;
`endif
                    end
                end
                MOVE: begin
                    if (step_tick) begin
                        if (cur_player) begin
                            p1_tile <= stepped_tile;
                        end else begin
                            p0_tile <= stepped_tile;
                        end
                        steps_left <= steps_after;
                        timer      <= RELOAD;
`ifdef BOUNCE_BACK_EN
                        if (stepped_tile == LAST) begin
                            dir <= 1'b1;
                        end
`endif
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                DONE: begin
                    move_done <= 1'b1;
                    busy      <= 1'b0;
                    if (active_tile == LAST) begin
                        game_over <= 1'b1;
                        winner    <= cur_player;
                    end else begin
                        cur_player <= ~cur_player;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_player_move_ctrl.sv
// ---------------------------------------------------------------------------
// tb_player_move_ctrl
//
// Self-checking bench for player_move_ctrl with a short step period. A
// behavioural game model (tile per player, whose turn, winner) predicts the
// token path of each move as a list of tiles and derives the expected
// outputs cycle by cycle from step count and step period. Honours the
// BOUNCE_BACK_EN build macro in the same way as the design.
// ---------------------------------------------------------------------------
module tb_player_move_ctrl;

    localparam int S    = 4;
    localparam int LAST = 9;

    logic       clk;
    logic       reset;
    logic       new_game;
    logic       dice_valid;
    logic [2:0] dice_value;
    logic [3:0] p0_tile;
    logic [3:0] p1_tile;
    logic       cur_player;
    logic       busy;
    logic       move_done;
    logic       game_over;
    logic       winner;

    int vectors     = 0;
    int miscompares = 0;
    int done_pulses = 0;

    // Behavioural game model.
    int mtile [2];
    bit mplayer;
    bit mgo;
    bit mwinner;

    player_move_ctrl #(
        .STEP_CYCLES(S),
        .LAST_TILE  (LAST)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .new_game  (new_game),
        .dice_valid(dice_valid),
        .dice_value(dice_value),
        .p0_tile   (p0_tile),
        .p1_tile   (p1_tile),
        .cur_player(cur_player),
        .busy      (busy),
        .move_done (move_done),
        .game_over (game_over),
        .winner    (winner)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts move_done pulses seen at falling edges.
    always @(negedge clk) begin
        if (move_done === 1'b1) done_pulses++;
    end

    // Hard stop in case anything stalls.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic model_clear();
        mtile[0] = 0;
        mtile[1] = 0;
        mplayer  = 1'b0;
        mgo      = 1'b0;
        mwinner  = 1'b0;
    endtask

    // Entered and left at a falling edge.
    task automatic pulse_new_game();
        new_game = 1'b1;
        @(posedge clk);
        @(negedge clk);
        new_game = 1'b0;
        model_clear();
    endtask

    // Offers one dice result and follows the whole move against the model.
    // interfere_at: cycle index within the move at which a stray dice strobe
    // is injected (ignored when outside the move).
    task automatic drive_move(input logic [2:0] d, input int interfere_at);
        int   path[$];
        int   t, n, k, cur_t, dn;
        bit   mover, win;
        logic [3:0] e0, e1;
        logic e_cur, e_busy, e_done, e_go, e_win;
`ifdef BOUNCE_BACK_EN
        bit   dir;
`endif
        mover = mplayer;
        dn    = int'(d);
        if (mgo || dn == 0 || dn == 7) begin
            dice_valid = 1'b1;
            dice_value = d;
            @(posedge clk);
            @(negedge clk);
            dice_valid = 1'b0;
            for (int c = 0; c < 3; c++) begin
                vectors++;
                if (busy !== 1'b0 || move_done !== 1'b0 ||
                    p0_tile !== 4'(mtile[0]) || p1_tile !== 4'(mtile[1]) ||
                    cur_player !== mplayer || game_over !== mgo ||
                    winner !== (mgo ? mwinner : 1'b0)) begin
                    miscompares++;
                    $display("[TB] FAIL ignored_dice d=%0d c=%0d: got p0=%0d p1=%0d cur=%0b busy=%0b done=%0b over=%0b win=%0b, need p0=%0d p1=%0d cur=%0b busy=0 done=0 over=%0b win=%0b",
                             dn, c, p0_tile, p1_tile, cur_player, busy, move_done, game_over, winner,
                             mtile[0], mtile[1], mplayer, mgo, mgo ? mwinner : 1'b0);
                end
                @(posedge clk);
                @(negedge clk);
            end
            return;
        end

        // Predicted token path, one entry per step actually taken.
        t = mtile[mover];
`ifdef BOUNCE_BACK_EN
        dir = 1'b0;
`endif
        for (int s = 0; s < dn; s++) begin
`ifdef BOUNCE_BACK_EN
            t = dir ? t - 1 : t + 1;
            path.push_back(t);
            if (t == LAST) dir = 1'b1;
`else
            t = t + 1;
            path.push_back(t);
            if (t == LAST) break;
`endif
        end
        n   = path.size();
        win = (path[n-1] == LAST);

        dice_valid = 1'b1;
        dice_value = d;
        @(posedge clk);
        @(negedge clk);
        dice_valid = 1'b0;

        // j counts rising edges since the accepting edge.
        for (int j = 0; j <= n*S + 2; j++) begin
            k      = (j / S < n) ? j / S : n;
            cur_t  = (k == 0) ? mtile[mover] : path[k-1];
            e0     = 4'(mtile[0]);
            e1     = 4'(mtile[1]);
            if (mover) e1 = 4'(cur_t);
            else       e0 = 4'(cur_t);
            e_busy = (j <= n*S);
            e_done = (j == n*S + 1);
            e_go   = win && (j > n*S);
            e_cur  = (j > n*S && !win) ? ~mover : mover;
            e_win  = e_go ? mover : 1'b0;
            vectors++;
            if (p0_tile !== e0 || p1_tile !== e1 || busy !== e_busy ||
                move_done !== e_done || game_over !== e_go ||
                cur_player !== e_cur || winner !== e_win) begin
                miscompares++;
                $display("[TB] FAIL move d=%0d j=%0d: got p0=%0d p1=%0d cur=%0b busy=%0b done=%0b over=%0b win=%0b, need p0=%0d p1=%0d cur=%0b busy=%0b done=%0b over=%0b win=%0b",
                         dn, j, p0_tile, p1_tile, cur_player, busy, move_done, game_over, winner,
                         e0, e1, e_cur, e_busy, e_done, e_go, e_win);
            end
            if (j == n*S + 2) break;
            if (j == interfere_at && j <= n*S) begin
                dice_valid = 1'b1;
                dice_value = 3'($urandom_range(1, 6));
            end
            @(posedge clk);
            @(negedge clk);
            dice_valid = 1'b0;
        end

        mtile[mover] = path[n-1];
        if (win) begin
            mgo     = 1'b1;
            mwinner = mover;
        end else begin
            mplayer = ~mover;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            vectors++;
            if (p0_tile !== 4'd0 || p1_tile !== 4'd0 || cur_player !== 1'b0 ||
                busy !== 1'b0 || move_done !== 1'b0 || game_over !== 1'b0 || winner !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset c=%0d: got p0=%0d p1=%0d cur=%0b busy=%0b done=%0b over=%0b win=%0b, need all 0",
                         c, p0_tile, p1_tile, cur_player, busy, move_done, game_over, winner);
            end
            reset = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        model_clear();
    endtask

    task automatic test_single_move();
        $display("[TB] single move, dice 3");
        drive_move(3'd3, -1);
        vectors++;
        if (p0_tile !== 4'd3 || p1_tile !== 4'd0 || cur_player !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL single_move_end: got p0=%0d p1=%0d cur=%0b, need p0=3 p1=0 cur=1",
                     p0_tile, p1_tile, cur_player);
        end
    endtask

    task automatic test_ignored();
        $display("[TB] ignored dice values and strobes while busy");
        drive_move(3'd0, -1);
        drive_move(3'd7, -1);
        drive_move(3'd4, 6);
        drive_move(3'd2, 2*S);
    endtask

    task automatic test_win();
        $display("[TB] run to goal from tile 7");
        pulse_new_game();
        drive_move(3'd3, -1);
        drive_move(3'd1, -1);
        drive_move(3'd4, -1);
        drive_move(3'd1, -1);
        drive_move(3'd5, -1);
        drive_move(3'd2, -1);
`ifndef BOUNCE_BACK_EN
        vectors++;
        if (game_over !== 1'b1 || winner !== 1'b0 || p0_tile !== 4'd9) begin
            miscompares++;
            $display("[TB] FAIL clamp_win: got over=%0b win=%0b p0=%0d, need over=1 win=0 p0=9",
                     game_over, winner, p0_tile);
        end
`endif
    endtask

    task automatic test_bounce();
        $display("[TB] player 1 from tile 7 with dice 5, then from 6 with dice 3");
        pulse_new_game();
        drive_move(3'd1, -1);
        drive_move(3'd4, -1);
        drive_move(3'd1, -1);
        drive_move(3'd3, -1);
        drive_move(3'd1, -1);
        drive_move(3'd5, -1);
        drive_move(3'd1, -1);
        drive_move(3'd3, -1);
        vectors++;
        if (game_over !== 1'b1 || winner !== 1'b1 || p1_tile !== 4'd9) begin
            miscompares++;
            $display("[TB] FAIL p1_win: got over=%0b win=%0b p1=%0d, need over=1 win=1 p1=9",
                     game_over, winner, p1_tile);
        end
    endtask

    task automatic test_new_game_abort();
        $display("[TB] new_game during a move");
        pulse_new_game();
        dice_valid = 1'b1;
        dice_value = 3'd4;
        @(posedge clk);
        @(negedge clk);
        dice_valid = 1'b0;
        for (int j = 0; j < 2*S; j++) begin
            vectors++;
            if (busy !== 1'b1 || p0_tile !== 4'(j / S)) begin
                miscompares++;
                $display("[TB] FAIL abort_pre j=%0d: got busy=%0b p0=%0d, need busy=1 p0=%0d",
                         j, busy, p0_tile, j / S);
            end
            if (j == 2*S - 1) new_game = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        new_game = 1'b0;
        model_clear();
        for (int c = 0; c < 2*S; c++) begin
            vectors++;
            if (p0_tile !== 4'd0 || p1_tile !== 4'd0 || busy !== 1'b0 ||
                move_done !== 1'b0 || cur_player !== 1'b0 || game_over !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL abort_post c=%0d: got p0=%0d p1=%0d busy=%0b done=%0b cur=%0b over=%0b, need all 0",
                         c, p0_tile, p1_tile, busy, move_done, cur_player, game_over);
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_alternate();
        int snap;
        $display("[TB] alternating turns 2/4/1");
        pulse_new_game();
        snap = done_pulses;
        drive_move(3'd2, -1);
        drive_move(3'd4, -1);
        drive_move(3'd1, -1);
        vectors++;
        if (p0_tile !== 4'd3 || p1_tile !== 4'd4 || done_pulses - snap != 3) begin
            miscompares++;
            $display("[TB] FAIL alternate: got p0=%0d p1=%0d pulses=%0d, need p0=3 p1=4 pulses=3",
                     p0_tile, p1_tile, done_pulses - snap);
        end
    endtask

    task automatic test_back_to_back();
        $display("[TB] randomized games");
        for (int g = 0; g < 3; g++) begin
            pulse_new_game();
            for (int m = 0; m < 40 && !mgo; m++) begin
                drive_move(3'($urandom_range(0, 7)), int'($urandom_range(0, 30)));
            end
            drive_move(3'($urandom_range(1, 6)), -1);
        end
    endtask

    initial begin
        reset      = 1'b1;
        new_game   = 1'b0;
        dice_valid = 1'b0;
        dice_value = 3'd0;
        model_clear();
        @(negedge clk);
        test_reset();
        test_single_move();
        test_ignored();
        test_win();
        test_bounce();
        test_new_game_abort();
        test_alternate();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/player_move_ctrl.md
Name: player_move_ctrl

Overview:
- Two-player token movement controller for the dice-race board.
- Accepts a dice result, then advances the active player's token one tile per step tick, so the display shows the token hopping tile by tile.
- Outputs the 0..9 tile index of each player. These feed the tile-to-coordinate mappers directly.
- Detects the win at tile 9 and alternates turns.

Parameters:
- STEP_CYCLES, 12_500_000: clock cycles between successive one-tile steps (0.5 s at 25 MHz). Must be >= 2.
- LAST_TILE, 9: goal tile index. Must be <= 15.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- new_game  input  1  synchronous restart pulse; same effect as reset
- dice_valid  input  1  one-cycle strobe: dice_value is valid
- dice_value  input  3  dice result; legal range 1..6
- p0_tile  output  4  player 0 tile index
- p1_tile  output  4  player 1 tile index
- cur_player  output  1  player whose turn it is / who is moving
- busy  output  1  high while a move is in progress
- move_done  output  1  one-cycle pulse when a move completes
- game_over  output  1  high once a player has won
- winner  output  1  winning player; valid when game_over=1

Behaviour:
- Reset values (reset, or new_game): p0_tile=0, p1_tile=0, cur_player=0, busy=0, move_done=0, game_over=0, winner=0, state=IDLE, step timer=0, steps_left=0.
- Priority: reset > new_game > all else. new_game mid-move aborts the move with no move_done.
- States:
  - IDLE: waiting for a dice result.
  - MOVE: stepping the active token.
  - DONE: single cycle that finishes the move.
  - OVER: game finished.
- Accept rule (IDLE only): dice_valid=1 and dice_value in 1..6. Then:
  - steps_left <= dice_value
  - timer <= STEP_CYCLES-1
  - busy <= 1
  - go to MOVE
- Ignored inputs, with no state change:
  - dice_value of 0 or 7
  - dice_valid while in MOVE, DONE or OVER
- MOVE:
  - Timer decrements every cycle.
  - When timer==0: the active token moves one tile, steps_left decrements, timer reloads to STEP_CYCLES-1.
  - If the step brings steps_left to 0, or the token reaches LAST_TILE: go to DONE.
- Overshoot: the token clamps at LAST_TILE and the remaining steps are discarded.
- Latency: with accept at cycle T, step k updates the tile at T+k*STEP_CYCLES. move_done=1 at T+n*STEP_CYCLES+1, where n is the number of steps actually taken.
- DONE (1 cycle):
  - move_done=1 and busy <= 0.
  - If the mover's tile == LAST_TILE: game_over <= 1, winner <= mover, go to OVER. cur_player is unchanged.
  - Otherwise: cur_player toggles, go to IDLE.
- OVER: holds all outputs until reset or new_game.
- Only the active player's tile ever changes. The idle player's tile is constant throughout a move.
- Tile outputs are registered and change only on step ticks.

Optional Feature:
- Macro: BOUNCE_BACK_EN.
- When defined:
  - Reaching LAST_TILE with steps remaining reverses direction; the remaining steps decrement the tile.
  - The move ends only when steps_left reaches 0.
  - A win requires landing exactly on LAST_TILE at the end of the move.
  - Direction resets to forward at every accept.
- When undefined: clamp behaviour as above, and no direction register exists.

Test Plan:
1. STEP_CYCLES=4. After reset, dice 3 accepted at cycle T -> p0_tile 1,2,3 at T+4, T+8, T+12. move_done at T+13. cur_player=1. p1_tile stays 0.
2. dice_value 0 and 7, and a dice_valid while busy -> no state change, busy stays as before, tiles unchanged.
3. p0 at 7, dice 5, macro undefined -> tiles 8, 9, then DONE. move_done 1 cycle after the 9. game_over=1, winner=0. A later dice_valid is ignored.
4. BOUNCE_BACK_EN defined, p1 at 7, dice 5 -> tiles 8,9,8,7,6. No win. cur_player -> 0. Separately, p1 at 6 with dice 3 -> 9 and game_over=1.
5. new_game asserted at the 2nd step of a 4-step move -> next cycle both tiles 0, busy=0, no move_done, cur_player=0.
6. Alternating turns: dice 2 (p0), dice 4 (p1), dice 1 (p0) -> p0_tile=3, p1_tile=4, exactly three move_done pulses.
